// File: rtl/picosoc_a2_cmdq.sv
// picosoc_a2_cmdq: Apple II bus command byte FIFOs drained over PicoSoC iomem; define A2CMDQ_IRQ_EN for IRQ_MASK (0x50) and irq
module picosoc_a2_cmdq #(
    parameter int          NUM_CH    = 4,
    parameter int          DEPTH     = 8,
    parameter logic [15:0] BASE_ADDR = 16'hC7F8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        iomem_valid,
    input  logic [3:0]  iomem_wstrb,
    input  logic [31:0] iomem_addr,
    input  logic [31:0] iomem_wdata,
    output logic [31:0] iomem_rdata,
    output logic        iomem_ready,
    input  logic [15:0] a2_addr,
    input  logic [7:0]  a2_data,
    input  logic        a2_rw_n,
    input  logic        a2_data_in_strobe
`ifdef A2CMDQ_IRQ_EN
    ,
    output logic        irq
`endif
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [7:0]        mem_q [NUM_CH][DEPTH];
    logic [AW-1:0]     rp_q [NUM_CH], rp_d [NUM_CH], wp_q [NUM_CH], wp_d [NUM_CH];
    logic [CW-1:0]     cnt_q [NUM_CH], cnt_d [NUM_CH];
    logic [NUM_CH-1:0] ovf_q, ovf_d, push, pop, flush, wen, ne;
    logic              ready_q, ready_d, busy_q, busy_d, start, wr;
    logic [31:0]       rdata_q, rdata_d;
    logic [5:0]        word;
    logic [7:0]        ne8, ovf8;
    logic              unused;
`ifdef A2CMDQ_IRQ_EN
    logic [NUM_CH-1:0] irq_mask_q, irq_mask_d;
    logic              irq_q, irq_d;
`endif

    assign word        = iomem_addr[7:2];
    assign wr          = |iomem_wstrb;
    // busy keeps a request that stays asserted past its ready pulse from being served twice
    assign start       = iomem_valid && !ready_q && !busy_q;
    assign busy_d      = iomem_valid && (start || busy_q);
    assign ready_d     = start;
    assign ne8         = 8'(ne);
    assign ovf8        = 8'(ovf_q);
    assign iomem_ready = ready_q;
    assign iomem_rdata = rdata_q;
    assign unused      = ^{iomem_addr, iomem_wdata};

    always_comb begin
        ovf_d = ovf_q;
        for (int c = 0; c < NUM_CH; c++) begin
            ne[c]    = |cnt_q[c];
            push[c]  = a2_data_in_strobe && !a2_rw_n && a2_addr == BASE_ADDR + 16'(c);
            pop[c]   = start && !wr && word == 6'(c) && ne[c];
            flush[c] = start && wr && word == 6'h13 && iomem_wdata[c];
            wen[c]   = push[c] && !flush[c] && (!cnt_q[c][AW] || pop[c]);
            rp_d[c]  = flush[c] ? '0 : pop[c] ? rp_q[c] + AW'(1) : rp_q[c];
            wp_d[c]  = flush[c] ? '0 : wen[c] ? wp_q[c] + AW'(1) : wp_q[c];
            cnt_d[c] = flush[c] ? '0 : cnt_q[c] + CW'(wen[c]) - CW'(pop[c]);
            ovf_d[c] = (ovf_q[c] && !(start && wr && word == 6'h10 && iomem_wdata[8+c]))
                    || (push[c] && cnt_q[c][AW] && !pop[c] && !flush[c]);
        end
    end

    always_comb begin
        rdata_d = '0;
        if (start && !wr) begin
            if (word == 6'h10) rdata_d = {16'b0, ovf8, ne8};
            else if (word == 6'h11) rdata_d = 32'(cnt_q[0]);
`ifdef A2CMDQ_IRQ_EN
            else if (word == 6'h14) rdata_d = 32'(irq_mask_q);
`endif
            for (int c = 0; c < NUM_CH; c++)
                if (word == 6'(c)) rdata_d = {23'b0, ne[c], ne[c] ? mem_q[c][rp_q[c]] : 8'h00};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            rdata_q <= '0;
            ovf_q   <= '0;
            rp_q    <= '{default: '0};
            wp_q    <= '{default: '0};
            cnt_q   <= '{default: '0};
        end else begin
            ready_q <= ready_d;
            busy_q  <= busy_d;
            rdata_q <= rdata_d;
            ovf_q   <= ovf_d;
            rp_q    <= rp_d;
            wp_q    <= wp_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk)
        for (int c = 0; c < NUM_CH; c++)
            if (wen[c]) mem_q[c][wp_q[c]] <= a2_data;

`ifdef A2CMDQ_IRQ_EN
    assign irq_mask_d = (start && wr && word == 6'h14) ? iomem_wdata[NUM_CH-1:0] : irq_mask_q;
    assign irq_d      = |((ne | ovf_q) & irq_mask_q);
    assign irq        = irq_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            irq_mask_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            irq_mask_q <= irq_mask_d;
            irq_q      <= irq_d;
        end
    end
`endif
endmodule

// File: tb/tb_picosoc_a2_cmdq.sv
// tb_picosoc_a2_cmdq: directed bench with a list-based reference model checked every cycle
module tb_picosoc_a2_cmdq;
    localparam int          NUM_CH = 4;
    localparam int          DEPTH  = 8;
    localparam logic [15:0] BASE   = 16'hC7F8;

    logic        clk = 0, reset = 1;
    logic        iomem_valid = 0;
    logic [3:0]  iomem_wstrb = 0;
    logic [31:0] iomem_addr = 0, iomem_wdata = 0;
    logic [31:0] iomem_rdata;
    logic        iomem_ready;
    logic [15:0] a2_addr = 0;
    logic [7:0]  a2_data = 0;
    logic        a2_rw_n = 1, a2_data_in_strobe = 0;
`ifdef A2CMDQ_IRQ_EN
    logic        irq;
`endif

    int n_vec = 0, n_err = 0;
    bit chk_on = 0;

    picosoc_a2_cmdq #(.NUM_CH(NUM_CH), .DEPTH(DEPTH), .BASE_ADDR(BASE)) dut (
        .clk(clk), .reset(reset),
        .iomem_valid(iomem_valid), .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
        .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata), .iomem_ready(iomem_ready),
        .a2_addr(a2_addr), .a2_data(a2_data), .a2_rw_n(a2_rw_n), .a2_data_in_strobe(a2_data_in_strobe)
`ifdef A2CMDQ_IRQ_EN
        , .irq(irq)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: each channel is an ordered list of bytes, oldest first
    logic [7:0]        mq [NUM_CH][DEPTH];
    int                msz [NUM_CH];
    logic [NUM_CH-1:0] movf, mmask;
    logic              exp_ready, exp_irq, served;
    logic [31:0]       exp_rdata;

    always @(posedge clk) begin : model
        logic st, wrt;
        logic [5:0] w;
        logic [31:0] rd;
        logic [NUM_CH-1:0] nev, clr, fl;
        if (reset) begin
            for (int c = 0; c < NUM_CH; c++) msz[c] = 0;
            movf = '0; mmask = '0; exp_ready = 0; exp_rdata = 0; exp_irq = 0; served = 0;
        end else begin
            for (int c = 0; c < NUM_CH; c++) nev[c] = msz[c] != 0;
            exp_irq = |((nev | movf) & mmask);
            st  = iomem_valid && !exp_ready && !served;
            served = iomem_valid && (served || st);
            wrt = |iomem_wstrb;
            w   = iomem_addr[7:2];
            rd  = 0;
            if (st && !wrt) begin
                if (w < NUM_CH) begin
                    if (msz[w] > 0) begin
                        rd = {23'b0, 1'b1, mq[w][0]};
                        for (int i = 0; i < DEPTH - 1; i++) mq[w][i] = mq[w][i+1];
                        msz[w]--;
                    end
                end else if (w == 6'h10) rd = {16'b0, 8'(movf), 8'(nev)};
                else if (w == 6'h11) rd = msz[0];
`ifdef A2CMDQ_IRQ_EN
                else if (w == 6'h14) rd = 32'(mmask);
`endif
            end
            clr = (st && wrt && w == 6'h10) ? iomem_wdata[8 +: NUM_CH] : '0;
            fl  = (st && wrt && w == 6'h13) ? iomem_wdata[NUM_CH-1:0] : '0;
            movf &= ~clr;
            for (int c = 0; c < NUM_CH; c++) begin
                if (fl[c]) msz[c] = 0;
                else if (a2_data_in_strobe && !a2_rw_n && a2_addr == BASE + 16'(c)) begin
                    if (msz[c] < DEPTH) begin
                        mq[c][msz[c]] = a2_data;
                        msz[c]++;
                    end else movf[c] = 1;
                end
            end
`ifdef A2CMDQ_IRQ_EN
            if (st && wrt && w == 6'h14) mmask = iomem_wdata[NUM_CH-1:0];
`endif
            exp_ready = st;
            exp_rdata = rd;
        end
    end

    always @(negedge clk) if (chk_on) begin
        check("ready", {31'b0, iomem_ready}, {31'b0, exp_ready});
        check("rdata", iomem_rdata, exp_rdata);
`ifdef A2CMDQ_IRQ_EN
        check("irq", {31'b0, irq}, {31'b0, exp_irq});
`endif
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic xfer(input logic [31:0] a, input bit w, input logic [31:0] d,
                        input bit p, input logic [15:0] pa, input logic [7:0] pd,
                        output logic [31:0] r);
        int n = 0;
        iomem_addr = a; iomem_wstrb = w ? 4'hF : 4'h0; iomem_wdata = d; iomem_valid = 1;
        if (p) begin a2_addr = pa; a2_data = pd; a2_rw_n = 0; a2_data_in_strobe = 1; end
        do begin
            tick(); n++;
            a2_data_in_strobe = 0; a2_rw_n = 1;
        end while (!iomem_ready && n < 8);
        check("ready_seen", {31'b0, iomem_ready}, 32'd1);
        r = iomem_rdata;
        iomem_valid = 0; iomem_wstrb = 0;
        tick();
    endtask

    task automatic rdchk(input logic [31:0] a, input logic [31:0] exp, input string nm);
        logic [31:0] r;
        xfer(a, 0, 0, 0, 0, 0, r);
        check(nm, r, exp);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] r;
        xfer(a, 1, d, 0, 0, 0, r);
    endtask

    task automatic push_raw(input logic [15:0] pa, input logic [7:0] pd, input logic rw);
        a2_addr = pa; a2_data = pd; a2_rw_n = rw; a2_data_in_strobe = 1;
        tick();
        a2_data_in_strobe = 0; a2_rw_n = 1;
    endtask

    task automatic push(input logic [15:0] pa, input logic [7:0] pd);
        push_raw(pa, pd, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] r, got;
        int pulses;
        tick(); tick();
        chk_on = 1;
        reset = 0;
        tick();
        check("reset_ready", {31'b0, iomem_ready}, 0);
        check("reset_rdata", iomem_rdata, 0);
        rdchk(32'h40, 32'h0, "reset_status");

        push(16'hC7F8, 8'h41);
        rdchk(32'h00, 32'h141, "ch0_first");
        rdchk(32'h00, 32'h000, "ch0_empty");

        for (int i = 1; i <= 9; i++) push(16'hC7F9, 8'(i));
        rdchk(32'h40, 32'h0202, "ch1_ovf_status");
        for (int i = 1; i <= 8; i++) rdchk(32'h04, 32'h100 + i, "ch1_drain");
        wr(32'h40, 32'h200);
        rdchk(32'h40, 32'h0, "ch1_w1c");

        push(16'hC7F8, 8'h11); push(16'hC7F8, 8'h22); push(16'hC7F8, 8'h33);
        rdchk(32'h44, 32'd3, "count3");
        iomem_addr = 32'h00; iomem_wstrb = 0; iomem_valid = 1;
        pulses = 0; got = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (iomem_ready) begin pulses++; got = iomem_rdata; end end
        iomem_valid = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (iomem_ready) pulses++; end
        check("hold3_pulses", pulses, 1);
        check("hold3_data", got, 32'h111);
        rdchk(32'h44, 32'd2, "hold3_count");

        for (int i = 0; i < 8; i++) push(16'hC7FA, 8'hA0 + 8'(i));
        xfer(32'h08, 0, 0, 1, 16'hC7FA, 8'hAA, r);
        check("full_pop_push", r, 32'h1A0);
        rdchk(32'h40, 32'h0005, "full_pop_push_status");
        for (int i = 1; i < 8; i++) rdchk(32'h08, 32'h1A0 + i, "ch2_drain");
        rdchk(32'h08, 32'h1AA, "ch2_last");
        rdchk(32'h08, 32'h0, "ch2_empty");

        for (int i = 0; i < 3; i++) push(16'hC7FB, 8'h30 + 8'(i));
        xfer(32'h4C, 1, 32'h08, 1, 16'hC7FB, 8'h55, r);
        rdchk(32'h40, 32'h0001, "flush_push_status");
        rdchk(32'h0C, 32'h0, "ch3_flushed");
        wr(32'h4C, 32'h01);
        rdchk(32'h44, 32'd0, "ch0_flushed");

        for (int i = 0; i < 9; i++) push(16'hC7F9, 8'h60 + 8'(i));
        xfer(32'h40, 1, 32'h200, 1, 16'hC7F9, 8'h70, r);
        rdchk(32'h40, 32'h0202, "set_beats_clear");
        wr(32'h40, 32'h200);
        rdchk(32'h40, 32'h0002, "clear_after");
        wr(32'h4C, 32'h02);

        push_raw(16'hC7F8, 8'h99, 1);
        push(16'hC7FC, 8'h98);
        push(16'hC7F7, 8'h97);
        rdchk(32'h40, 32'h0, "no_stray_push");
        rdchk(32'h60, 32'h0, "unmapped_rd");
        push(16'hC7F8, 8'h77);
        wr(32'h00, 32'hFF);
        wr(32'h60, 32'hFFFF);
`ifndef A2CMDQ_IRQ_EN
        wr(32'h50, 32'hF);
        rdchk(32'h50, 32'h0, "mask_absent");
`endif
        rdchk(32'h40, 32'h0001, "unmapped_wr_status");
        rdchk(32'h00, 32'h177, "unmapped_wr_data");

        push(16'hC7F8, 8'h12);
        iomem_addr = 32'h40; iomem_wstrb = 0; iomem_valid = 1; reset = 1;
        tick();
        reset = 0; iomem_valid = 0;
        pulses = 0;
        for (int i = 0; i < 3; i++) begin tick(); if (iomem_ready) pulses++; end
        check("abort_pulses", pulses, 0);
        rdchk(32'h40, 32'h0, "abort_status");

`ifdef A2CMDQ_IRQ_EN
        wr(32'h50, 32'h1);
        rdchk(32'h50, 32'h1, "mask_rd");
        push(16'hC7F8, 8'h5A);
        check("irq_pre", {31'b0, irq}, 0);
        tick();
        check("irq_set", {31'b0, irq}, 1);
        rdchk(32'h00, 32'h15A, "irq_pop");
        check("irq_drop", {31'b0, irq}, 0);
`endif
        tick();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
